alu_req_arbiter: RTL

- Shares one ALU instance between two requesters.
- Round-robin arbitration picks one request, drives the ALU input bus with both operands valid (INP_VALID=2'b11) for a single cycle, and waits the command-dependent latency.
- Captures the ALU result and flags, then returns them to the winning requester over a valid/ready response channel.
- Illegal commands are rejected locally without ever reaching the ALU.

---
 rtl/alu_req_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One transaction in flight: accept, issue for one cycle, wait out the latency, return the result.
module alu_req_arbiter #(
    parameter int unsigned OP_WIDTH  = 8,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned LAT       = 1,
    parameter int unsigned MUL_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    RST_N,
    input  logic                    CE,
    input  logic [1:0]              REQ_VALID,
    output logic [1:0]              REQ_READY,
    input  logic [1:0]              REQ_MODE,
    input  logic [2*CMD_WIDTH-1:0]  REQ_CMD,
    input  logic [2*OP_WIDTH-1:0]   REQ_OPA,
    input  logic [2*OP_WIDTH-1:0]   REQ_OPB,
    input  logic [1:0]              REQ_CIN,
    output logic [1:0]              ALU_INP_VALID,
    output logic                    ALU_MODE,
    output logic [CMD_WIDTH-1:0]    ALU_CMD,
    output logic [OP_WIDTH-1:0]     ALU_OPA,
    output logic [OP_WIDTH-1:0]     ALU_OPB,
    output logic                    ALU_CIN,
    input  logic [OP_WIDTH:0]       ALU_RES,
    input  logic                    ALU_ERR,
    input  logic                    ALU_COUT,
    input  logic                    ALU_OFLOW,
    input  logic                    ALU_G,
    input  logic                    ALU_L,
    input  logic                    ALU_E,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic                    RSP_ID,
    output logic [OP_WIDTH:0]       RSP_RES,
    output logic                    RSP_ERR,
    output logic                    RSP_COUT,
    output logic                    RSP_OFLOW,
    output logic                    RSP_G,
    output logic                    RSP_L,
    output logic                    RSP_E
);

    localparam int unsigned MaxLat = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  win_q, win_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  alu_mode_q, alu_mode_d;
    logic [CMD_WIDTH-1:0]  alu_cmd_q, alu_cmd_d;
    logic [OP_WIDTH-1:0]   alu_opa_q, alu_opa_d;
    logic [OP_WIDTH-1:0]   alu_opb_q, alu_opb_d;
    logic                  alu_cin_q, alu_cin_d;
    logic [OP_WIDTH:0]     rsp_res_q, rsp_res_d;
    logic [5:0]            rsp_flags_q, rsp_flags_d;  // {err, cout, oflow, g, l, e}

    logic                  win_sel;
    logic                  sel_mode;
    logic [CMD_WIDTH-1:0]  sel_cmd;
    logic [OP_WIDTH-1:0]   sel_opa, sel_opb;
    logic                  sel_cin;
    logic                  sel_legal;
    logic                  is_mul;

    assign win_sel  = REQ_VALID[ptr_q] ? ptr_q : ~ptr_q;
    assign sel_mode = REQ_MODE[win_sel];
    assign sel_cin  = REQ_CIN[win_sel];
    assign sel_cmd  = win_sel ? REQ_CMD[2*CMD_WIDTH-1:CMD_WIDTH] : REQ_CMD[CMD_WIDTH-1:0];
    assign sel_opa  = win_sel ? REQ_OPA[2*OP_WIDTH-1:OP_WIDTH] : REQ_OPA[OP_WIDTH-1:0];
    assign sel_opb  = win_sel ? REQ_OPB[2*OP_WIDTH-1:OP_WIDTH] : REQ_OPB[OP_WIDTH-1:0];
    assign sel_legal = sel_mode ? (sel_cmd <= CMD_WIDTH'(10)) : (sel_cmd <= CMD_WIDTH'(13));
    assign is_mul = alu_mode_q && ((alu_cmd_q == CMD_WIDTH'(9)) || (alu_cmd_q == CMD_WIDTH'(10)));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        alu_mode_d  = alu_mode_q;
        alu_cmd_d   = alu_cmd_q;
        alu_opa_d   = alu_opa_q;
        alu_opb_d   = alu_opb_q;
        alu_cin_d   = alu_cin_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        REQ_READY   = 2'b00;
        if (CE) begin
            unique case (state_q)
                StIdle: begin
                    if (|REQ_VALID) begin
                        REQ_READY[win_sel] = 1'b1;
                        win_d = win_sel;
                        if (sel_legal) begin
                            alu_mode_d = sel_mode;
                            alu_cmd_d  = sel_cmd;
                            alu_opa_d  = sel_opa;
                            alu_opb_d  = sel_opb;
                            alu_cin_d  = sel_cin;
                            state_d    = StIssue;
                        end else begin
                            // Rejected locally: the ALU bus is left untouched.
                            rsp_res_d   = '0;
                            rsp_flags_d = 6'b100000;
                            state_d     = StResp;
                        end
                    end
                end
                StIssue: begin
                    cnt_d   = is_mul ? CntW'(MUL_LAT - 1) : CntW'(LAT - 1);
                    state_d = StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        rsp_res_d   = ALU_RES;
                        rsp_flags_d = {ALU_ERR, ALU_COUT, ALU_OFLOW, ALU_G, ALU_L, ALU_E};
                        state_d     = StResp;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    if (RSP_READY) begin
                        ptr_d   = ~win_q;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            win_q       <= 1'b0;
            cnt_q       <= '0;
            alu_mode_q  <= 1'b0;
            alu_cmd_q   <= '0;
            alu_opa_q   <= '0;
            alu_opb_q   <= '0;
            alu_cin_q   <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            alu_mode_q  <= alu_mode_d;
            alu_cmd_q   <= alu_cmd_d;
            alu_opa_q   <= alu_opa_d;
            alu_opb_q   <= alu_opb_d;
            alu_cin_q   <= alu_cin_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign ALU_INP_VALID = (state_q == StIssue) ? 2'b11 : 2'b00;
    assign ALU_MODE      = alu_mode_q;
    assign ALU_CMD       = alu_cmd_q;
    assign ALU_OPA       = alu_opa_q;
    assign ALU_OPB       = alu_opb_q;
    assign ALU_CIN       = alu_cin_q;

    assign RSP_VALID = (state_q == StResp);
    assign RSP_ID    = win_q;
    assign RSP_RES   = rsp_res_q;
    assign {RSP_ERR, RSP_COUT, RSP_OFLOW, RSP_G, RSP_L, RSP_E} = rsp_flags_q;

endmodule
